// File: rtl/sram_pkg.sv
// Shared constants and FSM state type for the packet-buffer SRAM read path.
package sram_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sram_rd_fifo.sv
// Small synchronous skid FIFO holding captured SRAM words plus their last flag.
module sram_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_ok_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok_s = pop && (count_r != CW'(0));
  assign head     = mem_r[rd_ptr_r];
  assign empty    = (count_r == CW'(0));
  assign count    = count_r;

  // Storage, pointers and occupancy; memory cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + CW'(push) - CW'(pop_ok_s);
    end
  end

endmodule

// File: rtl/sram_burst_reader.sv
// Burst read initiator for the packet-buffer SRAM: issues credited reads and streams words out.
// Optional macro SRAM_RD_STATS_EN adds saturating stat_words / stat_stalls counters.
module sram_burst_reader
  import sram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_rd_addr,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
`ifdef SRAM_RD_STATS_EN
  ,
  output logic [31:0]       stat_words,
  output logic [31:0]       stat_stalls
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_e         state_r;
  rd_state_e         state_s;
  logic [ADDR_W-1:0] next_addr_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [LEN_W-1:0]  rem_r;
  logic [CW-1:0]     inflight_r;
  logic              rd_en_r;
  logic              rd_last_r;
  logic              cap_en_r;
  logic              cap_last_r;
  logic              busy_r;
  logic              req_ready_r;
  logic [CW-1:0]     fifo_count_s;
  logic              fifo_empty_s;
  logic [DATA_W:0]   head_s;
  logic              start_s;
  logic              credit_s;
  logic              issue_s;
  logic              pop_s;

  assign start_s  = req_valid && req_ready_r && (req_len != LEN_W'(0));
  // Reads still in the SRAM pipeline count against FIFO space so a capture can never overflow.
  assign credit_s = ({1'b0, fifo_count_s} + {1'b0, inflight_r}) < (CW+1)'(FIFO_DEPTH);
  assign issue_s  = (state_r == RD_ISSUE) && (rem_r != LEN_W'(0)) && credit_s;
  assign pop_s    = out_valid && out_ready;

  assign req_ready    = req_ready_r;
  assign busy         = busy_r;
  assign sram_rd_en   = rd_en_r;
  assign sram_rd_addr = rd_addr_r;
  assign out_valid    = !fifo_empty_s;
  assign out_data     = head_s[DATA_W-1:0];
  assign out_last     = head_s[DATA_W];

  // Next-state logic for the burst FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RD_IDLE: begin
        if (start_s) state_s = RD_ISSUE;
        else         state_s = RD_IDLE;
      end
      RD_ISSUE: begin
        if ((rem_r == LEN_W'(0)) || (issue_s && (rem_r == LEN_W'(1)))) state_s = RD_DRAIN;
        else                                                           state_s = RD_ISSUE;
      end
      RD_DRAIN: begin
        if (pop_s && out_last) state_s = RD_IDLE;
        else                   state_s = RD_DRAIN;
      end
      default: state_s = RD_IDLE;
    endcase
  end

  // State register with registered busy / req_ready derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RD_IDLE;
      busy_r      <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != RD_IDLE);
      req_ready_r <= (state_s == RD_IDLE);
    end
  end

  // Read issue: the accepted request launches the first read directly, later reads wait for credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_r     <= 1'b0;
      rd_last_r   <= 1'b0;
      rd_addr_r   <= '0;
      next_addr_r <= '0;
      rem_r       <= '0;
      cap_en_r    <= 1'b0;
      cap_last_r  <= 1'b0;
      inflight_r  <= '0;
    end else begin
      if (start_s) begin
        rd_en_r     <= 1'b1;
        rd_last_r   <= (req_len == LEN_W'(1));
        rd_addr_r   <= req_addr;
        next_addr_r <= req_addr + ADDR_W'(1);
        rem_r       <= req_len - LEN_W'(1);
      end else if (issue_s) begin
        rd_en_r     <= 1'b1;
        rd_last_r   <= (rem_r == LEN_W'(1));
        rd_addr_r   <= next_addr_r;
        next_addr_r <= next_addr_r + ADDR_W'(1);
        rem_r       <= rem_r - LEN_W'(1);
      end else begin
        rd_en_r     <= 1'b0;
        rd_last_r   <= 1'b0;
      end
      cap_en_r   <= rd_en_r;
      cap_last_r <= rd_last_r;
      inflight_r <= inflight_r + CW'(start_s || issue_s) - CW'(cap_en_r);
    end
  end

  sram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cap_en_r),
    .push_data ({cap_last_r, sram_dout}),
    .pop       (pop_s),
    .head      (head_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

`ifdef SRAM_RD_STATS_EN
  logic [31:0] words_r;
  logic [31:0] stalls_r;

  // Saturating handshake and stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_r  <= 32'd0;
      stalls_r <= 32'd0;
    end else begin
      if (pop_s && (words_r != 32'hFFFF_FFFF)) words_r <= words_r + 32'd1;
      if (out_valid && !out_ready && (stalls_r != 32'hFFFF_FFFF)) stalls_r <= stalls_r + 32'd1;
    end
  end

  assign stat_words  = words_r;
  assign stat_stalls = stalls_r;
`endif

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed self-checking bench for sram_burst_reader with a behavioural 1-cycle-latency SRAM.
module tb_sram_burst_reader;
  import sram_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_rd_addr;
  logic [DATA_W-1:0] sram_dout;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
`ifdef SRAM_RD_STATS_EN
  logic [31:0]       stat_words;
  logic [31:0]       stat_stalls;
`endif

  sram_burst_reader #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .sram_rd_en   (sram_rd_en),
    .sram_rd_addr (sram_rd_addr),
    .sram_dout    (sram_dout),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy)
`ifdef SRAM_RD_STATS_EN
    ,
    .stat_words   (stat_words),
    .stat_stalls  (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    return {a, 2'b01} ^ 16'h3C5A;
  endfunction

  // SRAM model: data valid the cycle after the read enable, junk otherwise.
  initial begin
    sram_dout = 16'hBEEE;
    forever begin
      @(posedge clk);
      if (sram_rd_en) sram_dout <= mem_f(sram_rd_addr);
      else            sram_dout <= 16'hBEEE;
    end
  end

  logic [ADDR_W-1:0] rdaddr_q [$];
  logic [DATA_W-1:0] data_q [$];
  logic              last_q [$];
  int issued, popped, occ_max, hold_err, stalls, rr_low;
  int first_rd_cyc, first_ov_cyc, hs_cyc;
  logic stall_prev, held_last;
  logic [DATA_W-1:0] held_data;
  bit toggle_en = 1'b0;

  task automatic clear_mon();
    rdaddr_q.delete(); data_q.delete(); last_q.delete();
    issued = 0; popped = 0; occ_max = 0; hold_err = 0; stalls = 0; rr_low = 0;
    first_rd_cyc = -1; first_ov_cyc = -1; hs_cyc = -1;
    stall_prev = 1'b0; held_last = 1'b0; held_data = '0;
  endtask

  // Monitor sampling on the falling edge.
  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      if (req_valid && req_ready) hs_cyc = cyc;
      if (!req_ready) rr_low++;
      if (sram_rd_en) begin
        rdaddr_q.push_back(sram_rd_addr);
        issued++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (issued - popped > occ_max) occ_max = issued - popped;
      if (stall_prev && (!out_valid || out_data !== held_data || out_last !== held_last)) hold_err++;
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
      if (stall_prev) stalls++;
      if (out_valid && out_ready) begin
        data_q.push_back(out_data);
        last_q.push_back(out_last);
        popped++;
      end
    end
  end

  // Optional out_ready toggler for back-pressure tests.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) out_ready = ~out_ready;
    end
  end

  task automatic do_req(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_len = n;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && !out_valid) done = 1'b1;
    end
    check({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic check_burst(input string tag, input logic [ADDR_W-1:0] base, input int len);
    logic [ADDR_W-1:0] a;
    check({tag, "_nbeats"}, 32'(data_q.size()), 32'(len));
    check({tag, "_nreads"}, 32'(rdaddr_q.size()), 32'(len));
    a = base;
    for (int i = 0; i < len; i++) begin
      if (i < rdaddr_q.size()) check({tag, "_addr"}, 32'(rdaddr_q[i]), 32'(a));
      if (i < data_q.size()) begin
        check({tag, "_data"}, 32'(data_q[i]), 32'(mem_f(a)));
        check({tag, "_last"}, 32'(last_q[i]), 32'(i == len - 1));
      end
      a = a + ADDR_W'(1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rd_en"},     32'(sram_rd_en), 32'd0);
    check({tag, "_rd_addr"},   32'(sram_rd_addr), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data), 32'd0);
    check({tag, "_out_last"},  32'(out_last), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, s0;
    bit got3;
    w0 = 0; s0 = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: basic burst with latency check
    clear_mon();
    do_req(14'h0010, 8'd4);
    wait_done("t1", 40);
    check_burst("t1", 14'h0010, 4);
    check("t1_rd_lat", 32'(first_rd_cyc - hs_cyc), 32'd1);
    check("t1_ov_lat", 32'(first_ov_cyc - hs_cyc), 32'd3);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_ready_after", 32'(req_ready), 32'd1);

    // 2: address wrap
    clear_mon();
    do_req(14'h3FFE, 8'd4);
    wait_done("t2", 40);
    check_burst("t2", 14'h3FFE, 4);

    // 3: back-pressure with toggling out_ready
`ifdef SRAM_RD_STATS_EN
    w0 = int'(stat_words); s0 = int'(stat_stalls);
`endif
    clear_mon();
    toggle_en = 1'b1;
    do_req(14'h0200, 8'd16);
    wait_done("t3", 200);
    toggle_en = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    check_burst("t3", 14'h0200, 16);
    check("t3_hold", 32'(hold_err), 32'd0);
    check("t3_occ_le_depth", 32'(occ_max <= 4), 32'd1);
    check("t3_occ_reaches_full", 32'(occ_max), 32'd4);
    check("t3_saw_stalls", 32'(stalls > 0), 32'd1);
`ifdef SRAM_RD_STATS_EN
    check("t3_stat_words", stat_words - 32'(w0), 32'd16);
    check("t3_stat_stalls", stat_stalls - 32'(s0), 32'(stalls));
`endif

    // 4: null burst
    clear_mon();
    do_req(14'h0040, 8'd0);
    repeat (6) @(negedge clk);
    check("t4_no_reads", 32'(issued), 32'd0);
    check("t4_no_valid", 32'(first_ov_cyc), 32'hFFFF_FFFF);
    check("t4_ready_high", 32'(rr_low), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);

    // 5: reset mid-burst, then a clean burst
    clear_mon();
    do_req(14'h0300, 8'd8);
    got3 = 1'b0;
    for (int i = 0; i < 40 && !got3; i++) begin
      @(negedge clk);
      if (popped >= 3) got3 = 1'b1;
    end
    check("t5_reach3_timeout", 32'(got3), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    do_req(14'h0100, 8'd2);
    wait_done("t5", 40);
    check_burst("t5", 14'h0100, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
